fnd_scan_decoder: RTL and testbench

- Receive end of the multiplexed 7-segment display bus. Samples the active-low segment lines (nFND) and anode lines (nANODE), waits for each digit to settle, and inverts the segment encoding back to 5-bit display codes.
- Assembles the three digits into a frame and republishes the displayed page number, or flags the waiting-chase pattern.
- Used as an on-board self-check/monitor and as the ModelSim scoreboard front-end for the display path.

---
 rtl/fnd_scan_decoder_pkg.sv | 73 +++++++
 rtl/fnd_scan_decoder_if.sv | 22 ++
 rtl/fnd_scan_decoder_seg_decode.sv | 48 ++++
 rtl/fnd_scan_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/fnd_scan_decoder_pkg.sv
// Shared constants for the 7-segment display path: segment bytes (active low),
// display codes, anode selects and the frame FSM state type.
package fnd_pkg;

   // Hex digit patterns, bit order {a,b,c,d,e,f,g,dp}, 0 = segment lit
   localparam logic [7:0] SEG_X0 = 8'h03;
   localparam logic [7:0] SEG_X1 = 8'h9F;
   localparam logic [7:0] SEG_X2 = 8'h25;
   localparam logic [7:0] SEG_X3 = 8'h0D;
   localparam logic [7:0] SEG_X4 = 8'h99;
   localparam logic [7:0] SEG_X5 = 8'h49;
   localparam logic [7:0] SEG_X6 = 8'h41;
   localparam logic [7:0] SEG_X7 = 8'h1B;
   localparam logic [7:0] SEG_X8 = 8'h01;
   localparam logic [7:0] SEG_X9 = 8'h09;
   localparam logic [7:0] SEG_XA = 8'h11;
   localparam logic [7:0] SEG_XB = 8'hC1;
   localparam logic [7:0] SEG_XC = 8'hE5;
   localparam logic [7:0] SEG_XD = 8'h85;
   localparam logic [7:0] SEG_XE = 8'h61;
   localparam logic [7:0] SEG_XF = 8'h71;

   localparam logic [7:0] SEG_A     = 8'h7F;
   localparam logic [7:0] SEG_B     = 8'hBF;
   localparam logic [7:0] SEG_C     = 8'hDF;
   localparam logic [7:0] SEG_D     = 8'hEF;
   localparam logic [7:0] SEG_E     = 8'hF7;
   localparam logic [7:0] SEG_F     = 8'hFB;
   localparam logic [7:0] SEG_G     = 8'hFD;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DP    = 8'hFE;

   localparam logic [4:0] CODE_SEG_A = 5'h10;
   localparam logic [4:0] CODE_BLANK = 5'h17;
   localparam logic [4:0] CODE_DP    = 5'h1F;

   localparam logic [2:0] AN_D2   = 3'b011;
   localparam logic [2:0] AN_D1   = 3'b101;
   localparam logic [2:0] AN_D0   = 3'b110;
   localparam logic [2:0] AN_NONE = 3'b111;

   localparam logic [14:0] DIGIT_CODE_RST = {CODE_BLANK, CODE_BLANK, CODE_BLANK};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HAVE2  = 2'd1,
      ST_HAVE21 = 2'd2
   } frame_state_e;

   typedef enum logic [1:0] {
      DIG_NONE = 2'd0,
      DIG_0    = 2'd1,
      DIG_1    = 2'd2,
      DIG_2    = 2'd3
   } digit_sel_e;

   // Anything other than exactly one low anode line selects nothing
   function automatic digit_sel_e anode_to_digit(input logic [2:0] an_n);
      digit_sel_e sel;
      case (an_n)
         AN_D2:   sel = DIG_2;
         AN_D1:   sel = DIG_1;
         AN_D0:   sel = DIG_0;
         default: sel = DIG_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic is_hex_code(input logic [4:0] code);
      return (code[4] == 1'b0);
   endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// Display bus plus decoded results. The driver/monitor side uses master,
// the scan decoder uses slave.
interface fnd_scan_decoder_if;
   logic [7:0]  nFND;
   logic [2:0]  nANODE;
   logic [11:0] PAGE;
   logic [14:0] DIGIT_CODE;
   logic        PAGE_VALID;
   logic        WAITMODE;
   logic        DECODE_ERR;
   logic        SCAN_STALL;

   modport master (
      output nFND, nANODE,
      input  PAGE, DIGIT_CODE, PAGE_VALID, WAITMODE, DECODE_ERR, SCAN_STALL
   );

   modport slave (
      input  nFND, nANODE,
      output PAGE, DIGIT_CODE, PAGE_VALID, WAITMODE, DECODE_ERR, SCAN_STALL
   );
endinterface

// File: rtl/fnd_scan_decoder_seg_decode.sv
// Inverse segment map: active-low segment byte to 5-bit display code.
// Unknown patterns decode as blank with err raised.
module fnd_seg_decode
   import fnd_pkg::*;
(
   input  logic [7:0] seg_n,
   output logic [4:0] code,
   output logic       err
);

   // Single table lookup; codes 10..16 are the lone segments a..g
   always_comb begin
      code = CODE_BLANK;
      err  = 1'b0;
      case (seg_n)
         SEG_X0:    code = 5'h00;
         SEG_X1:    code = 5'h01;
         SEG_X2:    code = 5'h02;
         SEG_X3:    code = 5'h03;
         SEG_X4:    code = 5'h04;
         SEG_X5:    code = 5'h05;
         SEG_X6:    code = 5'h06;
         SEG_X7:    code = 5'h07;
         SEG_X8:    code = 5'h08;
         SEG_X9:    code = 5'h09;
         SEG_XA:    code = 5'h0A;
         SEG_XB:    code = 5'h0B;
         SEG_XC:    code = 5'h0C;
         SEG_XD:    code = 5'h0D;
         SEG_XE:    code = 5'h0E;
         SEG_XF:    code = 5'h0F;
         SEG_A:     code = CODE_SEG_A;
         SEG_B:     code = 5'h11;
         SEG_C:     code = 5'h12;
         SEG_D:     code = 5'h13;
         SEG_E:     code = 5'h14;
         SEG_F:     code = 5'h15;
         SEG_G:     code = 5'h16;
         SEG_BLANK: code = CODE_BLANK;
         SEG_DP:    code = CODE_DP;
         default: begin
            code = CODE_BLANK;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Receive side of the multiplexed 7-segment bus: synchronise, wait for each
// digit to settle, decode, assemble 2->1->0 frames and publish the page.
module fnd_scan_decoder
   import fnd_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic MCLK,
   input logic RST,
   fnd_scan_decoder_if.slave bus
);

   localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
   localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT_CYCLES);

   logic [7:0]   fnd_meta_q, fnd_meta_d, fnd_sync_q, fnd_sync_d, fnd_prev_q, fnd_prev_d;
   logic [2:0]   an_meta_q, an_meta_d, an_sync_q, an_sync_d, an_prev_q, an_prev_d;
   logic [7:0]   settle_cnt_q, settle_cnt_d;
   logic         captured_q, captured_d;
   logic [15:0]  idle_cnt_q, idle_cnt_d;
   frame_state_e state_q, state_d;
   logic [4:0]   code2_q, code2_d, code1_q, code1_d;
   logic         err2_q, err2_d, err1_q, err1_d;
   logic [11:0]  page_q, page_d;
   logic [14:0]  digit_code_q, digit_code_d;
   logic         page_valid_q, page_valid_d;
   logic         waitmode_q, waitmode_d;
   logic         decode_err_q, decode_err_d;
   logic         scan_stall_q, scan_stall_d;

   digit_sel_e   digit_sel_s;
   logic         an_changed_s, stable_s, capture_s, stall_hit_s;
   logic [4:0]   dec_code_s;
   logic         dec_err_s;

   fnd_seg_decode u_seg_decode (
      .seg_n (fnd_sync_q),
      .code  (dec_code_s),
      .err   (dec_err_s)
   );

   // Synchroniser chain, settle counter and capture strobe
   always_comb begin
      fnd_meta_d   = bus.nFND;
      fnd_sync_d   = fnd_meta_q;
      fnd_prev_d   = fnd_sync_q;
      an_meta_d    = bus.nANODE;
      an_sync_d    = an_meta_q;
      an_prev_d    = an_sync_q;
      digit_sel_s  = anode_to_digit(an_sync_q);
      an_changed_s = (an_sync_q != an_prev_q);
      stable_s     = (digit_sel_s != DIG_NONE) && !an_changed_s && (fnd_sync_q == fnd_prev_q);
      settle_cnt_d = settle_cnt_q;
      if (!stable_s) begin
         settle_cnt_d = 8'd0;
      end else if (settle_cnt_q < SETTLE_MAX) begin
         settle_cnt_d = settle_cnt_q + 8'd1;
      end else begin
         settle_cnt_d = settle_cnt_q;
      end
      capture_s = stable_s && !captured_q && (settle_cnt_q == (SETTLE_MAX - 8'd1));
      if (an_changed_s) begin
         captured_d = 1'b0;
      end else if (capture_s) begin
         captured_d = 1'b1;
      end else begin
         captured_d = captured_q;
      end
   end

   // Stall watchdog; a capture always wins over saturation
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (capture_s) begin
         idle_cnt_d = 16'd0;
      end else if (idle_cnt_q < TIMEOUT_MAX) begin
         idle_cnt_d = idle_cnt_q + 16'd1;
      end else begin
         idle_cnt_d = idle_cnt_q;
      end
      stall_hit_s  = (idle_cnt_d == TIMEOUT_MAX);
      scan_stall_d = stall_hit_s;
   end

   // Frame assembly and publish; out-of-order digits silently restart the frame
   always_comb begin
      state_d      = state_q;
      code2_d      = code2_q;
      code1_d      = code1_q;
      err2_d       = err2_q;
      err1_d       = err1_q;
      page_d       = page_q;
      digit_code_d = digit_code_q;
      page_valid_d = 1'b0;
      waitmode_d   = waitmode_q;
      decode_err_d = decode_err_q;
      if (capture_s) begin
         case (digit_sel_s)
            DIG_2: begin
               state_d = ST_HAVE2;
               code2_d = dec_code_s;
               err2_d  = dec_err_s;
               err1_d  = 1'b0;
            end
            DIG_1: begin
               if (state_q == ST_HAVE2) begin
                  state_d = ST_HAVE21;
                  code1_d = dec_code_s;
                  err1_d  = dec_err_s;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            DIG_0: begin
               state_d = ST_IDLE;
               if (state_q == ST_HAVE21) begin
                  page_valid_d = 1'b1;
                  digit_code_d = {code2_q, code1_q, dec_code_s};
                  decode_err_d = err2_q | err1_q | dec_err_s;
                  if (is_hex_code(code2_q) && is_hex_code(code1_q) && is_hex_code(dec_code_s)) begin
                     page_d     = {code2_q[3:0], code1_q[3:0], dec_code_s[3:0]};
                     waitmode_d = 1'b0;
                  end else begin
                     page_d     = page_q;
                     waitmode_d = 1'b1;
                  end
               end else begin
                  page_valid_d = 1'b0;
               end
            end
            default: state_d = state_q;
         endcase
      end else if (stall_hit_s) begin
         state_d = ST_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   // Input-side registers
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         fnd_meta_q   <= 8'hFF;
         fnd_sync_q   <= 8'hFF;
         fnd_prev_q   <= 8'hFF;
         an_meta_q    <= 3'b111;
         an_sync_q    <= 3'b111;
         an_prev_q    <= 3'b111;
         settle_cnt_q <= 8'd0;
         captured_q   <= 1'b0;
         idle_cnt_q   <= 16'd0;
      end else begin
         fnd_meta_q   <= fnd_meta_d;
         fnd_sync_q   <= fnd_sync_d;
         fnd_prev_q   <= fnd_prev_d;
         an_meta_q    <= an_meta_d;
         an_sync_q    <= an_sync_d;
         an_prev_q    <= an_prev_d;
         settle_cnt_q <= settle_cnt_d;
         captured_q   <= captured_d;
         idle_cnt_q   <= idle_cnt_d;
      end
   end

   // Frame state and published outputs
   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         code2_q      <= CODE_BLANK;
         code1_q      <= CODE_BLANK;
         err2_q       <= 1'b0;
         err1_q       <= 1'b0;
         page_q       <= 12'h000;
         digit_code_q <= DIGIT_CODE_RST;
         page_valid_q <= 1'b0;
         waitmode_q   <= 1'b0;
         decode_err_q <= 1'b0;
         scan_stall_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         code2_q      <= code2_d;
         code1_q      <= code1_d;
         err2_q       <= err2_d;
         err1_q       <= err1_d;
         page_q       <= page_d;
         digit_code_q <= digit_code_d;
         page_valid_q <= page_valid_d;
         waitmode_q   <= waitmode_d;
         decode_err_q <= decode_err_d;
         scan_stall_q <= scan_stall_d;
      end
   end

   assign bus.PAGE       = page_q;
   assign bus.DIGIT_CODE = digit_code_q;
   assign bus.PAGE_VALID = page_valid_q;
   assign bus.WAITMODE   = waitmode_q;
   assign bus.DECODE_ERR = decode_err_q;
   assign bus.SCAN_STALL = scan_stall_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed bench for fnd_scan_decoder: drives the anode/segment scan and
// compares the published frame outputs against hand-computed values.
module tb_fnd_scan_decoder;
   import fnd_pkg::*;

   logic MCLK = 1'b0;
   logic RST  = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   pv_count = 0;
   int   exp_pv   = 0;

   fnd_scan_decoder_if bus ();

   fnd_scan_decoder #(
      .SETTLE_CYCLES  (16),
      .TIMEOUT_CYCLES (4096)
   ) dut (
      .MCLK (MCLK),
      .RST  (RST),
      .bus  (bus)
   );

   always #5 MCLK = ~MCLK;

   // Count every cycle PAGE_VALID is high; a stretched pulse inflates the count
   always @(negedge MCLK) begin
      if (bus.PAGE_VALID === 1'b1) pv_count++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic show(input logic [2:0] an, input logic [7:0] seg, input int n);
      bus.nANODE = an;
      bus.nFND   = seg;
      repeat (n) @(posedge MCLK);
      #1;
   endtask

   task automatic frame(input logic [7:0] s2, input logic [7:0] s1, input logic [7:0] s0);
      show(AN_D2, s2, 1024);
      show(AN_D1, s1, 1024);
      show(AN_D0, s0, 1024);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_page"}, 32'(bus.PAGE), 32'h000);
      check_eq({tag, "_code"}, 32'(bus.DIGIT_CODE), 32'h5EF7);
      check_eq({tag, "_pv"}, 32'(bus.PAGE_VALID), 32'd0);
      check_eq({tag, "_wait"}, 32'(bus.WAITMODE), 32'd0);
      check_eq({tag, "_err"}, 32'(bus.DECODE_ERR), 32'd0);
      check_eq({tag, "_stall"}, 32'(bus.SCAN_STALL), 32'd0);
   endtask

   initial begin
      int k;
      bus.nANODE = AN_NONE;
      bus.nFND   = SEG_BLANK;
      repeat (4) @(posedge MCLK);
      #1;
      check_reset_outputs("rst");
      RST = 1'b0;

      // Page 123
      frame(8'h9F, 8'h25, 8'h0D);
      exp_pv++;
      check_eq("p123_page", 32'(bus.PAGE), 32'h123);
      check_eq("p123_code", 32'(bus.DIGIT_CODE), 32'h0443);
      check_eq("p123_wait", 32'(bus.WAITMODE), 32'd0);
      check_eq("p123_err", 32'(bus.DECODE_ERR), 32'd0);
      check_eq("p123_pv", 32'(pv_count), 32'(exp_pv));
      frame(8'h9F, 8'h25, 8'h0D);
      frame(8'h9F, 8'h25, 8'h0D);
      exp_pv += 2;
      check_eq("p123_pv_rate", 32'(pv_count), 32'(exp_pv));

      // Chase frame keeps the old page
      frame(8'h7F, 8'hFF, 8'hFF);
      exp_pv++;
      check_eq("chase_code", 32'(bus.DIGIT_CODE), 32'h42F7);
      check_eq("chase_wait", 32'(bus.WAITMODE), 32'd1);
      check_eq("chase_page", 32'(bus.PAGE), 32'h123);
      check_eq("chase_err", 32'(bus.DECODE_ERR), 32'd0);

      // Unknown pattern on digit 1
      frame(8'h9F, 8'h5A, 8'h0D);
      exp_pv++;
      check_eq("bad_err", 32'(bus.DECODE_ERR), 32'd1);
      check_eq("bad_code", 32'(bus.DIGIT_CODE), 32'h06E3);
      check_eq("bad_wait", 32'(bus.WAITMODE), 32'd1);
      check_eq("bad_page", 32'(bus.PAGE), 32'h123);
      frame(8'h99, 8'h49, 8'h41);
      exp_pv++;
      check_eq("clean_err", 32'(bus.DECODE_ERR), 32'd0);
      check_eq("clean_page", 32'(bus.PAGE), 32'h456);
      check_eq("clean_code", 32'(bus.DIGIT_CODE), 32'h10A6);
      check_eq("clean_wait", 32'(bus.WAITMODE), 32'd0);
      check_eq("clean_pv", 32'(pv_count), 32'(exp_pv));

      // Glitching digit 0 must not capture; the settled value lands 2+16 cycles later
      show(AN_D2, 8'h1B, 1024);
      show(AN_D1, 8'h01, 1024);
      for (int i = 0; i < 20; i++) begin
         show(AN_D0, (i % 2 == 1) ? 8'h9F : 8'h03, 8);
      end
      check_eq("glitch_no_pv", 32'(pv_count), 32'(exp_pv));
      bus.nFND = 8'h09;
      k = 0;
      while (k < 100 && bus.PAGE_VALID !== 1'b1) begin
         @(posedge MCLK);
         #1;
         k++;
      end
      exp_pv++;
      check_eq("glitch_latency", 32'(k), 32'd19);
      check_eq("glitch_page", 32'(bus.PAGE), 32'h789);

      // Stall with a half-built frame pending, then resume
      show(AN_D2, 8'h03, 1024);
      show(AN_D1, 8'h9F, 19);
      bus.nANODE = AN_NONE;
      k = 0;
      while (k < 6000 && bus.SCAN_STALL !== 1'b1) begin
         @(posedge MCLK);
         #1;
         k++;
      end
      check_eq("stall_latency", 32'(k), 32'd4096);
      show(AN_NONE, SEG_BLANK, 904);
      check_eq("stall_hold", 32'(bus.SCAN_STALL), 32'd1);
      check_eq("stall_no_pv", 32'(pv_count), 32'(exp_pv));
      show(AN_D0, 8'h0D, 1024);
      check_eq("resume_stall_clr", 32'(bus.SCAN_STALL), 32'd0);
      check_eq("resume_forced_idle", 32'(pv_count), 32'(exp_pv));
      frame(8'h99, 8'h1B, 8'h25);
      exp_pv++;
      check_eq("resume_page", 32'(bus.PAGE), 32'h472);
      check_eq("resume_pv", 32'(pv_count), 32'(exp_pv));

      // Reset while in HAVE21 drops the partial frame
      show(AN_D2, 8'h03, 1024);
      show(AN_D1, 8'h03, 1024);
      RST = 1'b1;
      #2;
      check_reset_outputs("midrst");
      repeat (3) @(posedge MCLK);
      #1;
      RST = 1'b0;
      show(AN_D0, 8'h0D, 1024);
      check_eq("midrst_no_pv", 32'(pv_count), 32'(exp_pv));
      check_eq("midrst_page_held", 32'(bus.PAGE), 32'h000);
      frame(8'h0D, 8'h71, 8'h71);
      exp_pv++;
      check_eq("p3ff_page", 32'(bus.PAGE), 32'h3FF);
      check_eq("p3ff_code", 32'(bus.DIGIT_CODE), 32'h0DEF);
      check_eq("p3ff_wait", 32'(bus.WAITMODE), 32'd0);
      check_eq("p3ff_pv", 32'(pv_count), 32'(exp_pv));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
